data_ram_arbiter: RTL

DATA_RAM_ARBITER -- requirements
Module: data_ram_arbiter

---
 rtl/data_ram_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/data_ram_arbiter.sv
// Dual-master single-port data RAM with a power-on/reset clear sequence.
// Define ARB_ROUND_ROBIN_EN for round-robin conflict arbitration; otherwise master 0 has fixed priority.
module data_ram_arbiter #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          busy
);
  localparam int DEPTH = 1 << AW;

  // Handshake: a master holds req (with we/addr/wdata stable) until it sees gnt;
  // the access is taken on the rising edge where req & gnt are both high.
  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          m0_rvalid_q, m0_rvalid_d;
  logic          m1_rvalid_q, m1_rvalid_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;
  logic [DW-1:0] mem [DEPTH];

  logic          acc0, acc1;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;  // 1: master 1 was granted most recently
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == '1) state_d = ST_RUN;
    end
  end

  // Output logic: busy and combinational grants
  always_comb begin
    busy   = (state_q == ST_CLEAR);
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (state_q == ST_RUN) begin
      if (m0_req && m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        m0_gnt = last_q;
        m1_gnt = !last_q;
`else
        m0_gnt = 1'b1;
`endif
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  assign acc0 = m0_req & m0_gnt;
  assign acc1 = m1_req & m1_gnt;

  // Datapath: RAM write port mux and per-master read capture
  always_comb begin
    mem_we      = 1'b0;
    mem_waddr   = m0_addr;
    mem_wdata   = m0_wdata;
    m0_rvalid_d = acc0 && !m0_we;
    m1_rvalid_d = acc1 && !m1_we;
    m0_rdata_d  = m0_rvalid_d ? mem[m0_addr] : m0_rdata_q;
    m1_rdata_d  = m1_rvalid_d ? mem[m1_addr] : m1_rdata_q;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
    end else if (acc0 && m0_we) begin
      mem_we    = 1'b1;
    end else if (acc1 && m1_we) begin
      mem_we    = 1'b1;
      mem_waddr = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    last_d = last_q;
    if (acc1)      last_d = 1'b1;
    else if (acc0) last_d = 1'b0;
  end
`endif

  // Storage is deliberately not reset; the clear sequence initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule
